buffer_frag_mw: RTL and testbench
=================================

// Module: buffer_frag_mw
// PURPOSE
//  Parametrised multi-location circular buffer feeding the TL TX data-fragmentation path.
//  Accepts 1..MAX_WR_LOC payload locations per cycle and returns 1..MAX_RD_LOC locations per cycle, in order.
//  Tracks occupancy and raises back-pressure (buffer_ready) and start_fragment for the fragmentation FSM.
//  Adds per-cycle read sizing, TLP-last tracking and error flags over the fixed-mode buffer.
// PARAMETERS
//  DW_WIDTH     32  bits per DW
//  LOC_DW       8   DWs per location (LOC_W = LOC_DW*DW_WIDTH)
//  DEPTH        16  locations; power of two
//  MAX_WR_LOC   4   max locations written per cycle; must be <= DEPTH
//  MAX_RD_LOC   2   max locations read per cycle; must be <= DEPTH
//  FRAG_THRESH  4   occupancy that triggers start_fragment; range 1..DEPTH
// PORTS
//  clk             in   1                      clock; all logic on rising edge
//  arst            in   1                      reset, synchronous, active-high
//  wr_en           in   1                      write request
//  data_in         in   MAX_WR_LOC*LOC_W       location i at bits [i*LOC_W +: LOC_W]
//  no_loc_wr       in   $clog2(MAX_WR_LOC+1)   locations to write this cycle
//  wr_last         in   1                      write carries the final locations of a TLP payload
//  rd_en           in   1                      read request
//  no_loc_rd       in   $clog2(MAX_RD_LOC+1)   locations to read this cycle
//  data_out        out  MAX_RD_LOC*LOC_W       slot i = i-th oldest location read
//  rd_valid        out  1                      data_out valid, 1-cycle pulse per granted read
//  count           out  $clog2(DEPTH+1)        occupancy
//  buffer_ready    out  1                      free space >= MAX_WR_LOC
//  start_fragment  out  1                      fragmentation may start
//  wr_err, rd_err  out  1 each                 rejected-request pulses
// BEHAVIOUR
//  Reset (arst=1 at clk edge):
//   - wr_ptr, rd_ptr, count, pending_last, data_out, rd_valid, start_fragment, wr_err, rd_err -> 0.
//   - buffer_ready -> 1. Memory contents are not cleared (don't care).
//   - Reset applied mid-operation discards all stored data.
//  Write, decided against pre-cycle count: wn=no_loc_wr.
//   - Accept if wr_en & 1<=wn<=MAX_WR_LOC & wn<=DEPTH-count.
//   - On accept: mem[(wr_ptr+i)%DEPTH] <= data_in loc i for i<wn; wr_ptr += wn (mod DEPTH).
//   - wr_en & wn==0: no-op, no error.
//   - Any other wr_en: whole write dropped; wr_err=1 next cycle; no state change.
//  Read, decided against pre-cycle count: rn=no_loc_rd.
//   - Grant if rd_en & 1<=rn<=MAX_RD_LOC & rn<=count.
//   - On grant, next cycle: data_out slot i = mem[(rd_ptr+i)%DEPTH] for i<rn; slots >= rn are 0; rd_valid=1; rd_ptr += rn.
//   - rd_en & rn==0: no-op.
//   - Any other rd_en: rd_err=1 next cycle; rd_valid=0; data_out holds.
//   - Locations written in the same cycle cannot be read that cycle; there is no bypass.
//  Simultaneous read and write: count_next = count + wn_acc - rn_gnt; both are legal on the same cycle.
//  Pointers are $clog2(DEPTH) bits and wrap naturally.
//  All outputs are registered. Read latency is 1 cycle.
//  buffer_ready = (count_next <= DEPTH-MAX_WR_LOC).
//  pending_last: set on an accepted write with wr_last; cleared when count_next==0. Set takes priority if both occur.
//  start_fragment = (count_next >= FRAG_THRESH) | (pending_last_next & count_next != 0).
// TESTING
//  1. Reset: arst=1 for 2 cycles -> count=0, buffer_ready=1, start_fragment=0, rd_valid=0, data_out=0.
//  2. Write wn=4, loc i = {8{32'hA000_000i}}; then rd rn=2 twice ->
//     - data_out {A1,A0} then {A3,A2}, rd_valid=1 each.
//     - count 4 -> 2 -> 0.
//     - start_fragment=1 only while count=4.
//  3. Four writes of wn=4 -> buffer_ready 1 at count=12, 0 at count=16; fifth write wn=1 -> wr_err=1, count stays 16.
//  4. Wrap: five rounds of write wn=4, read rn=2 x2 -> pointers cross 15->0; data returned in order; no errors.
//  5. Simultaneous events:
//     - count=3, write wn=4 + read rn=2 -> count=5, data_out = two oldest locations.
//     - count=1, rd rn=2 -> rd_err=1, rd_valid=0, count=1.
//  6. wr_last / mid-operation reset:
//     - Write wn=1 with wr_last -> start_fragment=1 at count=1.
//     - Read rn=1 -> count=0, start_fragment=0.
//     - Reset at count=7 -> count=0 next cycle.

Source files
------------

// File: rtl/buffer_frag_mw.sv
// buffer_frag_mw: multi-location circular buffer in front of the TL TX
// data-fragmentation path. Each cycle it can accept 1..MAX_WR_LOC locations
// and return 1..MAX_RD_LOC locations, oldest first. Occupancy drives
// back-pressure (buffer_ready) and the start_fragment hint for the
// fragmentation FSM. A request that cannot be honoured in full is dropped as a
// whole and reported with a one-cycle error pulse.
//
// Handshake: there is no ready/valid pairing on the inputs. A write is taken
// on any clock edge where wr_en=1 and the request fits the pre-cycle free
// space. A read is granted on any edge where rd_en=1 and the request fits the
// pre-cycle occupancy. A granted read presents its data one cycle later,
// qualified by a single-cycle rd_valid pulse. Locations written on a cycle
// are never visible to a read on that same cycle.
module buffer_frag_mw #(
  parameter int DW_WIDTH    = 32,
  parameter int LOC_DW      = 8,
  parameter int DEPTH       = 16,
  parameter int MAX_WR_LOC  = 4,
  parameter int MAX_RD_LOC  = 2,
  parameter int FRAG_THRESH = 4
) (
  input  logic                                       clk,
  input  logic                                       arst,
  input  logic                                       wr_en,
  input  logic [MAX_WR_LOC*LOC_DW*DW_WIDTH-1:0]      data_in,
  input  logic [$clog2(MAX_WR_LOC+1)-1:0]            no_loc_wr,
  input  logic                                       wr_last,
  input  logic                                       rd_en,
  input  logic [$clog2(MAX_RD_LOC+1)-1:0]            no_loc_rd,
  output logic [MAX_RD_LOC*LOC_DW*DW_WIDTH-1:0]      data_out,
  output logic                                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]                 count,
  output logic                                       buffer_ready,
  output logic                                       start_fragment,
  output logic                                       wr_err,
  output logic                                       rd_err
);

  localparam int LOC_W = LOC_DW * DW_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Sized copies of the parameters so every comparison is width-matched.
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_WR_C    = CNT_W'(MAX_WR_LOC);
  localparam logic [CNT_W-1:0] MAX_RD_C    = CNT_W'(MAX_RD_LOC);
  localparam logic [CNT_W-1:0] READY_LIM_C = CNT_W'(DEPTH - MAX_WR_LOC);
  localparam logic [CNT_W-1:0] FRAG_C      = CNT_W'(FRAG_THRESH);

  // Storage and bookkeeping state.
  logic [LOC_W-1:0]              r_mem [DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [CNT_W-1:0]              r_count;
  logic                          r_pending_last;
  logic [MAX_RD_LOC*LOC_W-1:0]   r_data_out;
  logic                          r_rd_valid;
  logic                          r_buffer_ready;
  logic                          r_start_fragment;
  logic                          r_wr_err;
  logic                          r_rd_err;

  // Request decode and next-state values.
  logic [CNT_W-1:0]              w_wn;
  logic [CNT_W-1:0]              w_rn;
  logic [CNT_W-1:0]              w_free;
  logic                          w_wr_ok;
  logic                          w_rd_ok;
  logic                          w_wr_bad;
  logic                          w_rd_bad;
  logic [CNT_W-1:0]              w_wn_acc;
  logic [CNT_W-1:0]              w_rn_gnt;
  logic [CNT_W-1:0]              w_count_next;
  logic                          w_pending_next;
  logic [MAX_RD_LOC*LOC_W-1:0]   w_rd_data;

  // Qualify both requests against the occupancy at the start of the cycle.
  always_comb begin
    w_wn     = CNT_W'(no_loc_wr);
    w_rn     = CNT_W'(no_loc_rd);
    w_free   = DEPTH_C - r_count;
    w_wr_ok  = wr_en && (w_wn != '0) && (w_wn <= MAX_WR_C) && (w_wn <= w_free);
    w_rd_ok  = rd_en && (w_rn != '0) && (w_rn <= MAX_RD_C) && (w_rn <= r_count);
    // A zero-size request is a silent no-op, never an error.
    w_wr_bad = wr_en && (w_wn != '0) && !w_wr_ok;
    w_rd_bad = rd_en && (w_rn != '0) && !w_rd_ok;
    w_wn_acc = w_wr_ok ? w_wn : '0;
    w_rn_gnt = w_rd_ok ? w_rn : '0;
  end

  // Occupancy and TLP-last tracking after this cycle's accepted traffic.
  always_comb begin
    w_count_next   = r_count + w_wn_acc - w_rn_gnt;
    w_pending_next = r_pending_last;
    if (w_count_next == '0) begin
      w_pending_next = 1'b0;
    end
    // A new final write wins over the empty-clear on the same cycle.
    if (w_wr_ok && wr_last) begin
      w_pending_next = 1'b1;
    end
  end

  // Gather the requested oldest locations; slots beyond the request read 0.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < MAX_RD_LOC; i++) begin
      if (i < int'(no_loc_rd)) begin
        w_rd_data[i*LOC_W +: LOC_W] = r_mem[r_rd_ptr + PTR_W'(i)];
      end
    end
  end

  // Memory write port: store the accepted locations at consecutive slots.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_WR_LOC; i++) begin
      if (w_wr_ok && (i < int'(no_loc_wr))) begin
        r_mem[r_wr_ptr + PTR_W'(i)] <= data_in[i*LOC_W +: LOC_W];
      end
    end
  end

  // Pointers, occupancy and registered outputs; reset discards all content.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_pending_last   <= 1'b0;
      r_data_out       <= '0;
      r_rd_valid       <= 1'b0;
      r_buffer_ready   <= 1'b1;
      r_start_fragment <= 1'b0;
      r_wr_err         <= 1'b0;
      r_rd_err         <= 1'b0;
    end else begin
      r_wr_ptr         <= r_wr_ptr + PTR_W'(w_wn_acc);
      r_rd_ptr         <= r_rd_ptr + PTR_W'(w_rn_gnt);
      r_count          <= w_count_next;
      r_pending_last   <= w_pending_next;
      r_rd_valid       <= w_rd_ok;
      r_wr_err         <= w_wr_bad;
      r_rd_err         <= w_rd_bad;
      r_buffer_ready   <= (w_count_next <= READY_LIM_C);
      r_start_fragment <= (w_count_next >= FRAG_C) ||
                          (w_pending_next && (w_count_next != '0));
      // data_out holds its last value unless a read is granted.
      if (w_rd_ok) begin
        r_data_out <= w_rd_data;
      end
    end
  end

  assign data_out       = r_data_out;
  assign rd_valid       = r_rd_valid;
  assign count          = r_count;
  assign buffer_ready   = r_buffer_ready;
  assign start_fragment = r_start_fragment;
  assign wr_err         = r_wr_err;
  assign rd_err         = r_rd_err;

endmodule

// File: tb/tb_buffer_frag_mw.sv
// Directed bench for buffer_frag_mw: a queue-based reference model predicts
// every registered output each cycle, plus literal checks on key points.
module tb_buffer_frag_mw;

  localparam int DW_WIDTH    = 32;
  localparam int LOC_DW      = 8;
  localparam int DEPTH       = 16;
  localparam int MAX_WR_LOC  = 4;
  localparam int MAX_RD_LOC  = 2;
  localparam int FRAG_THRESH = 4;
  localparam int LOC_W       = LOC_DW * DW_WIDTH;
  localparam int WN_W        = $clog2(MAX_WR_LOC + 1);
  localparam int RN_W        = $clog2(MAX_RD_LOC + 1);
  localparam int CNT_W       = $clog2(DEPTH + 1);

  // ---------------- clock / reset / DUT ----------------
  logic                          clk = 1'b0;
  logic                          arst;
  logic                          wr_en;
  logic [MAX_WR_LOC*LOC_W-1:0]   data_in;
  logic [WN_W-1:0]               no_loc_wr;
  logic                          wr_last;
  logic                          rd_en;
  logic [RN_W-1:0]               no_loc_rd;
  logic [MAX_RD_LOC*LOC_W-1:0]   data_out;
  logic                          rd_valid;
  logic [CNT_W-1:0]              count;
  logic                          buffer_ready;
  logic                          start_fragment;
  logic                          wr_err;
  logic                          rd_err;

  always #5 clk = ~clk;

  buffer_frag_mw #(
    .DW_WIDTH(DW_WIDTH), .LOC_DW(LOC_DW), .DEPTH(DEPTH),
    .MAX_WR_LOC(MAX_WR_LOC), .MAX_RD_LOC(MAX_RD_LOC), .FRAG_THRESH(FRAG_THRESH)
  ) dut (
    .clk(clk), .arst(arst), .wr_en(wr_en), .data_in(data_in),
    .no_loc_wr(no_loc_wr), .wr_last(wr_last), .rd_en(rd_en),
    .no_loc_rd(no_loc_rd), .data_out(data_out), .rd_valid(rd_valid),
    .count(count), .buffer_ready(buffer_ready),
    .start_fragment(start_fragment), .wr_err(wr_err), .rd_err(rd_err)
  );

  // ---------------- reference model ----------------
  logic [LOC_W-1:0]              model_q[$];
  bit                            m_pending;
  logic [MAX_RD_LOC*LOC_W-1:0]   exp_dout;
  bit                            exp_rd_valid;
  bit                            exp_ready;
  bit                            exp_sf;
  bit                            exp_wr_err;
  bit                            exp_rd_err;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [LOC_W-1:0] loc(input logic [31:0] v);
    return {LOC_DW{v}};
  endfunction

  // Whole-buffer view: reads take from the front, writes append at the back.
  task automatic model_step(input bit a, input bit we, input int wn,
                            input bit wl, input bit re, input int rn);
    int  cnt;
    bit  wacc;
    bit  rgnt;
    if (a) begin
      model_q.delete();
      m_pending    = 0;
      exp_dout     = '0;
      exp_rd_valid = 0;
      exp_ready    = 1;
      exp_sf       = 0;
      exp_wr_err   = 0;
      exp_rd_err   = 0;
      return;
    end
    cnt  = model_q.size();
    wacc = we && wn >= 1 && wn <= MAX_WR_LOC && wn <= DEPTH - cnt;
    rgnt = re && rn >= 1 && rn <= MAX_RD_LOC && rn <= cnt;
    exp_wr_err   = we && wn != 0 && !wacc;
    exp_rd_err   = re && rn != 0 && !rgnt;
    exp_rd_valid = rgnt;
    if (rgnt) begin
      exp_dout = '0;
      for (int i = 0; i < rn; i++) exp_dout[i*LOC_W +: LOC_W] = model_q.pop_front();
    end
    if (wacc) begin
      for (int i = 0; i < wn; i++) model_q.push_back(data_in[i*LOC_W +: LOC_W]);
    end
    if (wacc && wl) m_pending = 1;
    else if (model_q.size() == 0) m_pending = 0;
    exp_ready = model_q.size() <= DEPTH - MAX_WR_LOC;
    exp_sf    = (model_q.size() >= FRAG_THRESH) || (m_pending && model_q.size() != 0);
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [MAX_RD_LOC*LOC_W-1:0] act,
                       input logic [MAX_RD_LOC*LOC_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("count",          count,          model_q.size());
    check("buffer_ready",   buffer_ready,   exp_ready);
    check("start_fragment", start_fragment, exp_sf);
    check("rd_valid",       rd_valid,       exp_rd_valid);
    check("data_out",       data_out,       exp_dout);
    check("wr_err",         wr_err,         exp_wr_err);
    check("rd_err",         rd_err,         exp_rd_err);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs; location i of the write carries {8{tag+i}}.
  task automatic step(input bit a, input bit we, input int wn, input bit wl,
                      input bit re, input int rn, input logic [31:0] tag);
    arst      = a;
    wr_en     = we;
    no_loc_wr = WN_W'(wn);
    wr_last   = wl;
    rd_en     = re;
    no_loc_rd = RN_W'(rn);
    for (int i = 0; i < MAX_WR_LOC; i++) data_in[i*LOC_W +: LOC_W] = loc(tag + 32'(i));
    model_step(a, we, wn, wl, re, rn);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wr(input int wn, input logic [31:0] tag);
    step(0, 1, wn, 0, 0, 0, tag);
  endtask

  task automatic rd(input int rn);
    step(0, 0, 0, 0, 1, rn, 32'h0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    arst = 1'b1; wr_en = 1'b0; data_in = '0; no_loc_wr = '0;
    wr_last = 1'b0; rd_en = 1'b0; no_loc_rd = '0;

    // 1. reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("lit_reset_count", count, 0);
    check("lit_reset_ready", buffer_ready, 1);
    check("lit_reset_sf", start_fragment, 0);
    check("lit_reset_dout", data_out, 0);

    // 2. basic write then two reads
    wr(4, 32'hA000_0000);
    check("lit_t2_count4", count, 4);
    check("lit_t2_sf_at4", start_fragment, 1);
    rd(2);
    check("lit_t2_dout0", data_out, {loc(32'hA000_0001), loc(32'hA000_0000)});
    check("lit_t2_count2", count, 2);
    check("lit_t2_sf_at2", start_fragment, 0);
    rd(2);
    check("lit_t2_dout1", data_out, {loc(32'hA000_0003), loc(32'hA000_0002)});
    check("lit_t2_count0", count, 0);

    // 3. fill to full, then an overflowing write
    for (int k = 0; k < 3; k++) wr(4, 32'hB000_0000 + 32'(k*16));
    check("lit_t3_ready12", buffer_ready, 1);
    wr(4, 32'hB000_0030);
    check("lit_t3_count16", count, 16);
    check("lit_t3_ready16", buffer_ready, 0);
    wr(1, 32'hBAD0_0000);
    check("lit_t3_wr_err", wr_err, 1);
    check("lit_t3_count_hold", count, 16);
    for (int k = 0; k < 8; k++) rd(2);

    // 4. pointer wrap rounds
    for (int k = 0; k < 5; k++) begin
      wr(4, 32'hC000_0000 + 32'(k*16));
      rd(2);
      rd(2);
    end

    // 5. simultaneous traffic and an over-read
    wr(3, 32'hD000_0000);
    step(0, 1, 4, 0, 1, 2, 32'hD100_0000);
    check("lit_t5_count5", count, 5);
    check("lit_t5_dout", data_out, {loc(32'hD000_0001), loc(32'hD000_0000)});
    rd(2); rd(2);
    rd(1);                         // leaves D100_0003 at count 0 -> nothing left
    wr(1, 32'hE000_0000);
    rd(2);
    check("lit_t5_rd_err", rd_err, 1);
    check("lit_t5_rd_valid", rd_valid, 0);
    check("lit_t5_count1", count, 1);
    wr(0, 32'h0);                  // zero-size requests are silent
    rd(0);
    step(0, 1, 5, 0, 1, 3, 32'hE100_0000);   // oversize on both ports
    rd(1);

    // 6. wr_last tracking and mid-operation reset
    step(0, 1, 1, 1, 0, 0, 32'hF000_0000);
    check("lit_t6_sf_last", start_fragment, 1);
    check("lit_t6_count1", count, 1);
    rd(1);
    check("lit_t6_sf_clear", start_fragment, 0);
    wr(4, 32'hF100_0000);
    step(0, 1, 3, 1, 0, 0, 32'hF200_0000);
    check("lit_t6_count7", count, 7);
    step(1, 0, 0, 0, 0, 0, 0);
    check("lit_t6_reset_count", count, 0);
    idle();
    wr(1, 32'hF300_0000);
    rd(1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
